// File: rtl/memory_map_io.sv
`default_nettype none
// ============================================================================
// Module      : memory_map_io
// Description : CPU address decoder for RAM, screen and a keyboard scancode
//               FIFO with status register and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_map_io #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 15,
    parameter int KBD_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              ram_we,
    output logic [ADDR_W-2:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              scr_we,
    output logic [ADDR_W-3:0] scr_addr,
    output logic [DATA_W-1:0] scr_wdata,
    input  logic [DATA_W-1:0] scr_rdata,
    input  logic [DATA_W-1:0] kbd_code,
    input  logic              kbd_strobe,
    output logic              kbd_irq,
    output logic              kbd_overflow,
    output logic              bus_err
);

    localparam int RAM_AW  = ADDR_W - 1;
    localparam int SCR_AW  = ADDR_W - 2;
    localparam int c_PTR_W = $clog2(KBD_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [ADDR_W-1:0]  c_KBD_DATA = {2'b11, {(ADDR_W-2){1'b0}}};
    localparam logic [ADDR_W-1:0]  c_KBD_STAT = {2'b11, {(ADDR_W-3){1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(KBD_DEPTH);

    localparam logic [1:0] c_SEL_RAM = 2'd0;
    localparam logic [1:0] c_SEL_SCR = 2'd1;
    localparam logic [1:0] c_SEL_REG = 2'd2;

    logic [1:0]         w_top;
    logic               w_sel_ram;
    logic               w_sel_scr;
    logic               w_sel_kdat;
    logic               w_sel_ksta;
    logic               w_unmapped;
    logic [1:0]         w_sel_code;

    logic [DATA_W-1:0]  r_kbd_mem [KBD_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_ovf_clr;
    logic               r_ovf;
    logic               r_bus_err;

    logic [DATA_W-1:0]  w_stat;
    logic [DATA_W-1:0]  w_head;
    logic [DATA_W-1:0]  w_reg_word;
    logic               r_valid;
    logic [1:0]         r_sel;
    logic [DATA_W-1:0]  r_reg_word;

    // Address decode
    assign w_top      = address[ADDR_W-1 -: 2];
    assign w_sel_ram  = ~address[ADDR_W-1];
    assign w_sel_scr  = (w_top == 2'b10);
    assign w_sel_kdat = (address == c_KBD_DATA);
    assign w_sel_ksta = (address == c_KBD_STAT);
    assign w_unmapped = (w_top == 2'b11) & ~w_sel_kdat & ~w_sel_ksta;

    assign w_sel_code = w_sel_ram ? c_SEL_RAM : (w_sel_scr ? c_SEL_SCR : c_SEL_REG);

    assign ram_we    = load & w_sel_ram;
    assign ram_addr  = address[RAM_AW-1:0];
    assign ram_wdata = in;
    assign scr_we    = load & w_sel_scr;
    assign scr_addr  = address[SCR_AW-1:0];
    assign scr_wdata = in;

    // Keyboard FIFO; a pop frees a slot for a same-cycle push even when full
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_pop     = rd_en & w_sel_kdat & ~w_empty;
    assign w_push    = kbd_strobe & (~w_full | w_pop);
    assign w_drop    = kbd_strobe & w_full & ~w_pop;
    assign w_ovf_clr = load & w_sel_ksta & in[0];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_kbd_mem[r_wptr] <= kbd_code;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            // A new overflow takes priority over a software clear
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_ovf_clr)
                r_ovf <= 1'b0;
            if ((load | rd_en) & w_unmapped)
                r_bus_err <= 1'b1;
        end
    end

    always_comb begin
        w_stat                = '0;
        w_stat[DATA_W-1]      = r_ovf;
        w_stat[c_CNT_W-1:0]   = r_count;
    end

    assign w_head     = w_empty ? '0 : r_kbd_mem[r_rptr];
    assign w_reg_word = w_sel_kdat ? w_head : (w_sel_ksta ? w_stat : '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_sel      <= c_SEL_RAM;
            r_reg_word <= '0;
        end else begin
            r_valid <= rd_en;
            if (rd_en) begin
                r_sel      <= w_sel_code;
                r_reg_word <= w_reg_word;
            end
        end
    end

    always_comb begin
        out = '0;
        if (r_valid) begin
            case (r_sel)
                c_SEL_RAM: out = ram_rdata;
                c_SEL_SCR: out = scr_rdata;
                default:   out = r_reg_word;
            endcase
        end
    end

    assign out_valid    = r_valid;
    assign kbd_irq      = ~w_empty;
    assign kbd_overflow = r_ovf;
    assign bus_err      = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_memory_map_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_map_io
// Description : Scoreboard bench for memory_map_io with RAM/screen models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_map_io;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in = '0;
    logic        load = 1'b0;
    logic        rd_en = 1'b0;
    logic [14:0] address = '0;
    logic [15:0] out;
    logic        out_valid;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        scr_we;
    logic [12:0] scr_addr;
    logic [15:0] scr_wdata;
    logic [15:0] scr_rdata;
    logic [15:0] kbd_code = '0;
    logic        kbd_strobe = 1'b0;
    logic        kbd_irq;
    logic        kbd_overflow;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    logic [15:0] ram_m [16384];
    logic [15:0] scr_m [8192];

    memory_map_io #(.DATA_W(16), .ADDR_W(15), .KBD_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .in(in), .load(load), .rd_en(rd_en),
        .address(address), .out(out), .out_valid(out_valid),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .scr_we(scr_we), .scr_addr(scr_addr), .scr_wdata(scr_wdata), .scr_rdata(scr_rdata),
        .kbd_code(kbd_code), .kbd_strobe(kbd_strobe), .kbd_irq(kbd_irq),
        .kbd_overflow(kbd_overflow), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    // Read-first synchronous memories
    always @(posedge clock) begin
        if (ram_we) ram_m[ram_addr] <= ram_wdata;
        ram_rdata <= ram_m[ram_addr];
        if (scr_we) scr_m[scr_addr] <= scr_wdata;
        scr_rdata <= scr_m[scr_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (out_valid) begin
            logic [15:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got out=%h expected no valid", out);
            end else begin
                e = exp_q.pop_front();
                if (out !== e) begin
                    errors++;
                    $display("FAIL read_data: got %h expected %h", out, e);
                end
            end
        end
    end

    task automatic do_read(input logic [14:0] a, input logic [15:0] e);
        rd_en   = 1'b1;
        address = a;
        exp_q.push_back(e);
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [14:0] a, input logic [15:0] d);
        load    = 1'b1;
        address = a;
        in      = d;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic push(input logic [15:0] c);
        kbd_strobe = 1'b1;
        kbd_code   = c;
        @(negedge clock);
        kbd_strobe = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", {16'd0, out}, 32'd0);
        check("rst_irq", {31'd0, kbd_irq}, 32'd0);
        check("rst_ovf", {31'd0, kbd_overflow}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // RAM write then read
        load = 1'b1; address = 15'h0005; in = 16'h1234;
        #1;
        check("ram_we", {31'd0, ram_we}, 32'd1);
        check("ram_addr", {18'd0, ram_addr}, 32'h5);
        check("ram_wdata", {16'd0, ram_wdata}, 32'h1234);
        check("ram_scr_we", {31'd0, scr_we}, 32'd0);
        @(negedge clock);
        load = 1'b0;
        #1;
        check("ram_we_idle", {31'd0, ram_we}, 32'd0);
        do_read(15'h0005, 16'h1234);

        // Screen write then read
        load = 1'b1; address = 15'h4010; in = 16'hBEEF;
        #1;
        check("scr_we", {31'd0, scr_we}, 32'd1);
        check("scr_addr", {19'd0, scr_addr}, 32'h10);
        check("scr_ram_we", {31'd0, ram_we}, 32'd0);
        @(negedge clock);
        load = 1'b0;
        do_read(15'h4010, 16'hBEEF);

        // Same-cycle write and read returns the old word
        load = 1'b1; in = 16'h5555;
        do_read(15'h0005, 16'h1234);
        load = 1'b0;
        do_read(15'h0005, 16'h5555);

        // Keyboard pop-on-read
        push(16'h0041);
        push(16'h0042);
        check("irq_set", {31'd0, kbd_irq}, 32'd1);
        do_write(15'h6000, 16'hFFFF);
        do_read(15'h6000, 16'h0041);
        check("irq_one_left", {31'd0, kbd_irq}, 32'd1);
        do_read(15'h6000, 16'h0042);
        check("irq_clear", {31'd0, kbd_irq}, 32'd0);
        do_read(15'h6000, 16'h0000);
        check("kdata_no_err", {31'd0, bus_err}, 32'd0);

        // Overflow and clear
        for (int i = 1; i <= 5; i++) push(16'(i));
        check("ovf_set", {31'd0, kbd_overflow}, 32'd1);
        do_read(15'h6001, 16'h8004);
        do_write(15'h6001, 16'h0001);
        check("ovf_clear", {31'd0, kbd_overflow}, 32'd0);
        do_read(15'h6001, 16'h0004);

        // Full FIFO: push and pop together
        kbd_strobe = 1'b1; kbd_code = 16'h0099;
        do_read(15'h6000, 16'h0001);
        kbd_strobe = 1'b0;
        check("full_pushpop_ovf", {31'd0, kbd_overflow}, 32'd0);
        do_read(15'h6001, 16'h0004);
        do_read(15'h6000, 16'h0002);
        do_read(15'h6000, 16'h0003);
        do_read(15'h6000, 16'h0004);
        do_read(15'h6000, 16'h0099);
        do_read(15'h6001, 16'h0000);

        // Unmapped access and reset mid-read
        check("bus_err_before", {31'd0, bus_err}, 32'd0);
        do_read(15'h7000, 16'h0000);
        check("bus_err_set", {31'd0, bus_err}, 32'd1);
        rd_en = 1'b1; address = 15'h7000;
        exp_q.push_back(16'h0000);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_mid_out", {16'd0, out}, 32'd0);
        rd_en = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_map_io.md
MEMORY_MAP_IO -- requirements
Module: memory_map_io

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data word width.
REQ-002 SHALL have parameter ADDR_W, default 15 (min 4): CPU address width; RAM_AW = ADDR_W-1 and SCR_AW = ADDR_W-2 are derived.
REQ-003 SHALL have parameter KBD_DEPTH, default 4 (power of 2, >=2): keyboard FIFO depth.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in  in  DATA_W  CPU write data.
- load  in  1  CPU write strobe.
- rd_en  in  1  CPU read strobe.
- address  in  ADDR_W  CPU word address.
- out  out  DATA_W  read data.
- out_valid  out  1  read data valid.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM synchronous read data, 1-cycle latency.
- scr_we  out  1  screen write enable.
- scr_addr  out  SCR_AW  screen address.
- scr_wdata  out  DATA_W  screen write data.
- scr_rdata  in  DATA_W  screen synchronous read data, 1-cycle latency.
- kbd_code  in  DATA_W  scancode from keyboard front end.
- kbd_strobe  in  1  single-cycle push of kbd_code.
- kbd_irq  out  1  keyboard FIFO non-empty.
- kbd_overflow  out  1  sticky: a push was dropped.
- bus_err  out  1  sticky: access to an unmapped address.

Function
REQ-005 SHALL decode the address as follows: address[ADDR_W-1]=0 selects RAM; top bits 10 select screen; KBD_DATA = 3<<(ADDR_W-2); KBD_STAT = KBD_DATA+1; every other address with top bits 11 is unmapped.
REQ-006 SHALL drive ram_addr and scr_addr combinationally from the low address bits, with ram_we = load&RAM-selected and scr_we = load&screen-selected; wdata outputs mirror in.
REQ-007 SHALL assert out_valid exactly one cycle after any cycle with rd_en=1, using the region select registered at request time to choose out: ram_rdata, scr_rdata, or the registered keyboard/status word. out SHALL be 0 whenever out_valid=0.
REQ-008 SHALL implement a keyboard FIFO of KBD_DEPTH entries with count width clog2(KBD_DEPTH)+1; a kbd_strobe pushes kbd_code.
REQ-009 SHALL treat rd_en at KBD_DATA as pop-on-read: it returns the head entry, or 0 when the FIFO is empty (no pop, no error).
REQ-010 SHALL, when a push and a pop occur in the same cycle on a full FIFO, perform both: the count is unchanged and kbd_overflow is not set.
REQ-011 SHALL, on a push to a full FIFO without a pop, drop the code and set kbd_overflow.
REQ-012 SHALL make a read of KBD_STAT return {overflow at bit DATA_W-1, zeros, count in the low bits}; load at KBD_STAT with in[0]=1 clears kbd_overflow; a same-cycle read returns the pre-clear value; a same-cycle new overflow wins over the clear.
REQ-013 SHALL ignore load at KBD_DATA (no state change, no error).
REQ-014 SHALL, on load or rd_en at an unmapped address, set bus_err (cleared only by reset), perform no write, and return 0 for the read with out_valid still asserted.
REQ-015 SHALL, when load and rd_en target the same RAM or screen address in one cycle, pass both to the memory; the returned data is the memory's read-first value.
REQ-016 SHALL drive kbd_irq = (count != 0) as a registered-state-derived output.

Reset
REQ-017 SHALL, while reset_n=0, asynchronously force FIFO pointers and count to 0, kbd_overflow=0, bus_err=0, out_valid=0 and out=0; a read in flight is discarded.
REQ-018 SHALL keep ram_we/scr_we combinational, so the memories are not written while load=0.

Verification
REQ-019 SHALL cover: write 0x1234 to 0x0005, then rd_en at 0x0005 -> ram_we pulse with ram_addr=5; next cycle out_valid=1, out=ram_rdata.
REQ-020 SHALL cover: load at 0x4010 -> scr_we=1, scr_addr=0x0010, ram_we=0.
REQ-021 SHALL cover: push codes 0x41,0x42 then read 0x6000 twice and once more -> out=0x41, 0x42, then 0; kbd_irq falls after the second pop.
REQ-022 SHALL cover: 5 pushes with KBD_DEPTH=4 -> kbd_overflow=1 and KBD_STAT=0x8004; write 1 to 0x6001 -> KBD_STAT reads 0x0004.
REQ-023 SHALL cover: full FIFO with push and pop in the same cycle -> count stays 4 and overflow stays 0.
REQ-024 SHALL cover: rd_en at 0x7000 -> out_valid=1, out=0, bus_err=1; assert reset_n=0 mid-read -> out_valid=0 and bus_err=0 immediately.
